// File: rtl/vm_controller.sv
// Vending machine controller: credit accumulation, product selection, dispenser
// handshake, change return and idle-timeout refund with registered outputs.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no credit held, waiting for a coin
// S_CREDIT   | credit > 0, accepting coins/selections, idle timer running
// S_DISPENSE | GetX held high, waiting for DispAck
// S_CHANGE   | one-cycle change return of the remaining credit
module vm_controller #(
    parameter int PRICE_MOJO   = 20,
    parameter int PRICE_FIZZUP = 25,
    parameter int CREDIT_MAX   = 50,
    parameter int CREDIT_W     = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Taka,
    input  logic [1:0]          TakaVal,
    input  logic                Mojo,
    input  logic                FizzUp,
    input  logic                Cancel,
    input  logic                DispAck,
    output logic                GetMojo,
    output logic                GetFizzUp,
    output logic                ChangeValid,
    output logic [CREDIT_W-1:0] ChangeAmt,
    output logic                Error,
    output logic [1:0]          ErrCode,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Busy
);

    localparam int SUM_W   = CREDIT_W + 1;
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SUM_W-1:0]    MAX_SUM    = SUM_W'(CREDIT_MAX);
    localparam logic [CREDIT_W-1:0] PRICE_M    = CREDIT_W'(PRICE_MOJO);
    localparam logic [CREDIT_W-1:0] PRICE_F    = CREDIT_W'(PRICE_FIZZUP);
    localparam logic [TIMER_W-1:0]  TIMEOUT_TC = TIMER_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 get_mojo_q, get_mojo_d;
    logic                 get_fizzup_q, get_fizzup_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amt_q, change_amt_d;
    logic                 error_q, error_d;
    logic [1:0]           err_code_q, err_code_d;
    logic                 busy_q, busy_d;
    logic                 coin_ok;
    logic [CREDIT_W-1:0]  coin_value;
    logic [SUM_W-1:0]     coin_sum;

    always_comb begin
        case (TakaVal)
            2'd0:    coin_value = CREDIT_W'(1);
            2'd1:    coin_value = CREDIT_W'(2);
            2'd2:    coin_value = CREDIT_W'(5);
            default: coin_value = CREDIT_W'(10);
        endcase
        coin_sum = {1'b0, credit_q} + {1'b0, coin_value};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            timer_q        <= '0;
            get_mojo_q     <= 1'b0;
            get_fizzup_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            error_q        <= 1'b0;
            err_code_q     <= 2'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            timer_q        <= timer_d;
            get_mojo_q     <= get_mojo_d;
            get_fizzup_q   <= get_fizzup_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            error_q        <= error_d;
            err_code_q     <= err_code_d;
            busy_q         <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        timer_d      = '0;
        get_mojo_d   = get_mojo_q;
        get_fizzup_d = get_fizzup_q;
        change_amt_d = '0;
        error_d      = 1'b0;
        err_code_d   = 2'd0;
        coin_ok      = 1'b0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (Taka) begin
                    if (!Cancel && !Mojo && !FizzUp && coin_sum <= MAX_SUM) begin
                        coin_ok  = 1'b1;
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
                // Selection faults are assigned after the coin so they win the code.
                if (Cancel) begin
                    if (state_q == S_CREDIT) begin
                        state_d = S_CHANGE;
                    end
                end else if (Mojo && FizzUp) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd1;
                end else if (Mojo) begin
                    if (credit_q >= PRICE_M) begin
                        credit_d   = credit_q - PRICE_M;
                        get_mojo_d = 1'b1;
                        state_d    = S_DISPENSE;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end
                end else if (FizzUp) begin
                    if (credit_q >= PRICE_F) begin
                        credit_d     = credit_q - PRICE_F;
                        get_fizzup_d = 1'b1;
                        state_d      = S_DISPENSE;
                    end else begin
                        error_d    = 1'b1;
                        err_code_d = 2'd2;
                    end
                end else if (!Taka && state_q == S_CREDIT && TIMEOUT != 0 &&
                             timer_q == TIMEOUT_TC) begin
                    state_d = S_CHANGE;
                end
            end
            S_DISPENSE: begin
                if (Taka) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd3;
                end
                if (DispAck) begin
                    get_mojo_d   = 1'b0;
                    get_fizzup_d = 1'b0;
                    state_d      = (credit_q != '0) ? S_CHANGE : S_IDLE;
                end
            end
            S_CHANGE: begin
                if (Taka) begin
                    error_d    = 1'b1;
                    err_code_d = 2'd3;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Entering CHANGE moves the whole credit into the change register.
        if (state_d == S_CHANGE) begin
            change_amt_d = credit_d;
            credit_d     = '0;
        end
        change_valid_d = (state_d == S_CHANGE);
        busy_d         = (state_d == S_DISPENSE) || (state_d == S_CHANGE);

        if (TIMEOUT != 0 && state_q == S_CREDIT && state_d == S_CREDIT &&
            !coin_ok && !error_d) begin
            timer_d = timer_q + TIMER_W'(1);
        end
    end

    assign GetMojo     = get_mojo_q;
    assign GetFizzUp   = get_fizzup_q;
    assign ChangeValid = change_valid_q;
    assign ChangeAmt   = change_amt_q;
    assign Error       = error_q;
    assign ErrCode     = err_code_q;
    assign Credit      = credit_q;
    assign Busy        = busy_q;

endmodule
